// File: rtl/hand_display_controller.sv
// Seven-segment controller for the blackjack board: sequential double-dabble
// conversion of every hand total, atomic commit of all hands to the display,
// a blinking game-result message and the win/loss LED banks.
module hand_display_controller #(
  parameter int NUM_HANDS       = 2,
  parameter int VALUE_W         = 5,
  parameter int DIGITS_PER_HAND = 2,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic                                   clk,
  input  logic                                   resetN,
  input  logic [NUM_HANDS*VALUE_W-1:0]           handValues,
  input  logic                                   update,
  input  logic [2:0]                             gameState,
  output logic [NUM_HANDS*DIGITS_PER_HAND*7-1:0] hexHands,
  output logic [27:0]                            hexMsg,
  output logic                                   busy,
  output logic [17:0]                            redLights,
  output logic [7:0]                             greenLights
);

  // The BCD register must hold every decimal digit of the widest total so an
  // overflow (more digits than are displayed) can be detected.
  localparam int NAT_DIGITS = (VALUE_W * 30103) / 100000 + 1;
  localparam int BCD_DIGITS = (NAT_DIGITS > DIGITS_PER_HAND) ? NAT_DIGITS : DIGITS_PER_HAND;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int HAND_W     = DIGITS_PER_HAND * 7;
  localparam int IDX_W      = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
  localparam int CNT_W      = $clog2(VALUE_W + 1);
  localparam int BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IDX_W-1:0]   LAST_HAND  = IDX_W'(NUM_HANDS - 1);
  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(VALUE_W - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [2:0] GS_BLJK = 3'd1;
  localparam logic [2:0] GS_TIE  = 3'd2;
  localparam logic [2:0] GS_WIN  = 3'd3;
  localparam logic [2:0] GS_LOSE = 3'd4;
  localparam logic [2:0] GS_BUST = 3'd5;

  typedef enum logic [1:0] {IDLE, SHIFT, STORE} conv_state_t;

  conv_state_t state, state_next;

  logic [NUM_HANDS*VALUE_W-1:0] latched;
  logic [IDX_W-1:0]             hand_idx;
  logic [CNT_W-1:0]             bit_count;
  logic [VALUE_W-1:0]           bin;
  logic [BCD_W-1:0]             bcd, bcd_adj;
  logic [BCD_W+VALUE_W-1:0]     dabble_next;
  logic                         pending;
  logic                         last_hand, restart;
  logic                         overflow, leading;
  logic [HAND_W-1:0]            hand_glyphs;
  logic [NUM_HANDS*HAND_W-1:0]  staging, staging_next;

  logic [2:0]         gs_q;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_next;
  logic               hidden, hidden_next;
  logic               gs_changed, blinking, losing;
  logic [27:0]        msg_glyphs;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign last_hand = (hand_idx == LAST_HAND);
  assign restart   = pending | update;

  // Conversion state register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // Next state: shift VALUE_W times, store, then next hand, restart or idle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (update) state_next = SHIFT;
      SHIFT:   if (bit_count == LAST_BIT) state_next = STORE;
      STORE:   state_next = (!last_hand || restart) ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy follows the state directly so a reset drops it without waiting.
  always_comb begin
    busy = (state != IDLE);
  end

  // Add-3 correction on every BCD digit before the shift of the same cycle.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < BCD_DIGITS; k++)
      if (bcd[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
    dabble_next = {bcd_adj, bin} << 1;
  end

  // Glyphs for the finished hand: dashes on overflow, leading zeros blanked.
  always_comb begin
    overflow = 1'b0;
    for (int k = DIGITS_PER_HAND; k < BCD_DIGITS; k++)
      if (bcd[k*4 +: 4] != 4'd0) overflow = 1'b1;
    leading     = 1'b1;
    hand_glyphs = '1;
    for (int d = DIGITS_PER_HAND - 1; d >= 0; d--) begin
      if (overflow) begin
        hand_glyphs[d*7 +: 7] = 7'h3F;
      end else if (leading && d != 0 && bcd[d*4 +: 4] == 4'd0) begin
        hand_glyphs[d*7 +: 7] = 7'h7F;
      end else begin
        leading               = 1'b0;
        hand_glyphs[d*7 +: 7] = seg_digit(bcd[d*4 +: 4]);
      end
    end
  end

  // Staging image with the current hand's glyphs merged in.
  always_comb begin
    staging_next = staging;
    staging_next[hand_idx*HAND_W +: HAND_W] = hand_glyphs;
  end

  // Conversion datapath, pending request and the atomic display commit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      latched   <= '0;
      hand_idx  <= '0;
      bit_count <= '0;
      bin       <= '0;
      bcd       <= '0;
      pending   <= 1'b0;
      staging   <= '1;
      hexHands  <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (update) begin
            latched   <= handValues;
            hand_idx  <= '0;
            bin       <= handValues[VALUE_W-1:0];
            bcd       <= '0;
            bit_count <= '0;
          end
        end
        SHIFT: begin
          bcd       <= dabble_next[BCD_W+VALUE_W-1:VALUE_W];
          bin       <= dabble_next[VALUE_W-1:0];
          bit_count <= bit_count + 1'b1;
          if (update) pending <= 1'b1;
        end
        STORE: begin
          staging   <= staging_next;
          bcd       <= '0;
          bit_count <= '0;
          if (!last_hand) begin
            hand_idx <= hand_idx + 1'b1;
            bin      <= latched[(hand_idx + 1) * VALUE_W +: VALUE_W];
            if (update) pending <= 1'b1;
          end else begin
            hexHands <= staging_next;
            if (restart) begin
              pending  <= 1'b0;
              latched  <= handValues;
              hand_idx <= '0;
              bin      <= handValues[VALUE_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Blink timing: a new game state restarts the visible phase.
  always_comb begin
    gs_changed = (gameState != gs_q);
    if (gs_changed) begin
      blink_cnt_next = '0;
      hidden_next    = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_next = '0;
      hidden_next    = ~hidden;
    end else begin
      blink_cnt_next = blink_cnt + 1'b1;
      hidden_next    = hidden;
    end
  end

  // Message glyph lookup for the current game state.
  always_comb begin
    blinking   = (gameState == GS_BLJK) || (gameState == GS_WIN);
    losing     = (gameState == GS_LOSE) || (gameState == GS_BUST);
    msg_glyphs = {4{7'h7F}};
    case (gameState)
      GS_BLJK: msg_glyphs = {7'h03, 7'h47, 7'h61, 7'h09};
      GS_TIE:  msg_glyphs = {7'h7F, 7'h07, 7'h79, 7'h06};
      GS_WIN:  msg_glyphs = {7'h41, 7'h41, 7'h79, 7'h2B};
      GS_LOSE: msg_glyphs = {7'h47, 7'h40, 7'h12, 7'h06};
      GS_BUST: msg_glyphs = {7'h03, 7'h41, 7'h12, 7'h07};
      default: ;
    endcase
  end

  // Registered message and lights, using the phase that applies after this edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gs_q        <= 3'd0;
      blink_cnt   <= '0;
      hidden      <= 1'b0;
      hexMsg      <= '1;
      greenLights <= 8'h00;
      redLights   <= 18'h0;
    end else begin
      gs_q        <= gameState;
      blink_cnt   <= blink_cnt_next;
      hidden      <= hidden_next;
      hexMsg      <= (blinking && hidden_next) ? 28'hFFFFFFF : msg_glyphs;
      greenLights <= (blinking && !hidden_next) ? 8'hFF : 8'h00;
      redLights   <= losing ? 18'h3FFFF : 18'h0;
    end
  end

endmodule

// File: tb/tb_hand_display_controller.sv
// Self-checking bench for hand_display_controller: a transaction-level model
// compared every cycle, plus directed literal expectations.
module tb_hand_display_controller;

  localparam int BLINK = 4;
  localparam int CONV  = 12;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [9:0]  hand_values = '0;
  logic        update = 1'b0;
  logic [2:0]  game_state = 3'd0;

  logic [27:0] hex_hands;
  logic [27:0] hex_msg;
  logic        busy;
  logic [17:0] red_lights;
  logic [7:0]  green_lights;

  logic [13:0] hex_hands_n;
  logic [27:0] hex_msg_n;
  logic        busy_n;
  logic [17:0] red_lights_n;
  logic [7:0]  green_lights_n;

  int tests_run = 0;
  int tests_failed = 0;

  int          busy_left = 0;
  bit          pending_m = 1'b0;
  int          latched_m [2];
  logic [27:0] exp_hands = '1;
  logic [13:0] exp_hands_n = '1;
  logic [27:0] exp_msg = '1;
  logic [7:0]  exp_green = '0;
  logic [17:0] exp_red = '0;
  int          k_blink = 0;
  logic [2:0]  gs_prev = 3'd0;

  hand_display_controller #(.NUM_HANDS(2), .VALUE_W(5), .DIGITS_PER_HAND(2), .BLINK_DIV(BLINK)) dut (
    .clk(clk), .resetN(resetN), .handValues(hand_values), .update(update), .gameState(game_state),
    .hexHands(hex_hands), .hexMsg(hex_msg), .busy(busy), .redLights(red_lights), .greenLights(green_lights)
  );

  hand_display_controller #(.NUM_HANDS(2), .VALUE_W(5), .DIGITS_PER_HAND(1), .BLINK_DIV(BLINK)) dut_n (
    .clk(clk), .resetN(resetN), .handValues(hand_values), .update(update), .gameState(game_state),
    .hexHands(hex_hands_n), .hexMsg(hex_msg_n), .busy(busy_n), .redLights(red_lights_n), .greenLights(green_lights_n)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] table_v [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return table_v[d];
  endfunction

  function automatic logic [6:0] glyph(input int v, input int digits, input int pos);
    if (v >= pow10(digits)) return 7'h3F;
    if (pos != 0 && v < pow10(pos)) return 7'h7F;
    return seg_of((v / pow10(pos)) % 10);
  endfunction

  function automatic logic [27:0] msg_of(input logic [2:0] gs);
    case (gs)
      3'd1:    return {7'h03, 7'h47, 7'h61, 7'h09};
      3'd2:    return {7'h7F, 7'h07, 7'h79, 7'h06};
      3'd3:    return {7'h41, 7'h41, 7'h79, 7'h2B};
      3'd4:    return {7'h47, 7'h40, 7'h12, 7'h06};
      3'd5:    return {7'h03, 7'h41, 7'h12, 7'h07};
      default: return {4{7'h7F}};
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a conversion is a fixed-length transaction that commits all hands at its end.
  initial begin
    logic vis;
    logic blink_state;
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        busy_left = 0; pending_m = 1'b0;
        exp_hands = '1; exp_hands_n = '1;
        exp_msg = '1; exp_green = '0; exp_red = '0;
        k_blink = 0; gs_prev = 3'd0;
      end else begin
        if (busy_left == 0) begin
          if (update) begin
            latched_m[0] = int'(hand_values[4:0]);
            latched_m[1] = int'(hand_values[9:5]);
            busy_left = CONV;
          end
        end else begin
          if (update) pending_m = 1'b1;
          busy_left--;
          if (busy_left == 0) begin
            for (int h = 0; h < 2; h++) begin
              for (int d = 0; d < 2; d++) exp_hands[(h*2+d)*7 +: 7] = glyph(latched_m[h], 2, d);
              exp_hands_n[h*7 +: 7] = glyph(latched_m[h], 1, 0);
            end
            if (pending_m) begin
              pending_m = 1'b0;
              latched_m[0] = int'(hand_values[4:0]);
              latched_m[1] = int'(hand_values[9:5]);
              busy_left = CONV;
            end
          end
        end
        if (game_state != gs_prev) k_blink = 0;
        else k_blink++;
        gs_prev = game_state;
        vis = ((k_blink / BLINK) % 2) == 0;
        blink_state = (game_state == 3'd1) || (game_state == 3'd3);
        exp_msg   = (blink_state && !vis) ? {4{7'h7F}} : msg_of(game_state);
        exp_green = (blink_state && vis) ? 8'hFF : 8'h00;
        exp_red   = (game_state == 3'd4 || game_state == 3'd5) ? 18'h3FFFF : 18'h0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check_output("busy", 64'(busy), 64'(busy_left != 0));
      check_output("hexHands", 64'(hex_hands), 64'(exp_hands));
      check_output("hexMsg", 64'(hex_msg), 64'(exp_msg));
      check_output("greenLights", 64'(green_lights), 64'(exp_green));
      check_output("redLights", 64'(red_lights), 64'(exp_red));
      check_output("busy_narrow", 64'(busy_n), 64'(busy_left != 0));
      check_output("hexHands_narrow", 64'(hex_hands_n), 64'(exp_hands_n));
    end
  end

  task automatic apply_stimulus(input logic [4:0] h0, input logic [4:0] h1);
    @(negedge clk);
    hand_values = {h1, h0};
    update = 1'b1;
    @(posedge clk);
    #2;
    update = 1'b0;
  endtask

  // Counts busy cycles; optionally strobes update at two cycle indices with a new hand0.
  task automatic wait_idle(input int pulse_a, input int pulse_b, input logic [4:0] new_h0, output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      cycles++;
      if (i == pulse_a) hand_values[4:0] = new_h0;
      update = (i == pulse_a) || (i == pulse_b);
      @(posedge clk);
      #2;
    end
    update = 1'b0;
  endtask

  initial begin
    int cycles;

    // 1: reset
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_busy", 64'(busy), 64'(0));
    check_output("reset_hands", 64'(hex_hands), 64'({4{7'h7F}}));
    check_output("reset_msg", 64'(hex_msg), 64'({4{7'h7F}}));
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_output("post_reset_lights", 64'({red_lights, green_lights}), 64'(0));

    // 2: basic conversion
    apply_stimulus(5'd21, 5'd7);
    wait_idle(-1, -1, 5'd0, cycles);
    check_output("conv_busy_len", 64'(cycles), 64'(12));
    check_output("conv_hands", 64'(hex_hands), 64'({7'h7F, 7'h78, 7'h24, 7'h79}));
    check_output("conv_hands_narrow", 64'(hex_hands_n), 64'({7'h78, 7'h3F}));

    // 3: update while busy, two strobes absorbed into one restart
    apply_stimulus(5'd5, 5'd19);
    wait_idle(3, 6, 5'd30, cycles);
    check_output("pending_busy_len", 64'(cycles), 64'(24));
    check_output("pending_hands", 64'(hex_hands), 64'({7'h79, 7'h10, 7'h30, 7'h40}));

    // 3b: update on the completion cycle
    apply_stimulus(5'd1, 5'd2);
    wait_idle(11, -1, 5'd20, cycles);
    check_output("edge_busy_len", 64'(cycles), 64'(24));
    check_output("edge_hands", 64'(hex_hands), 64'({7'h7F, 7'h24, 7'h24, 7'h40}));

    // 4: WIN blinking, then LOSE mid-hidden
    @(negedge clk);
    game_state = 3'd3;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_output("win_msg", 64'(hex_msg), (i < 4) ? 64'({7'h41, 7'h41, 7'h79, 7'h2B}) : 64'({4{7'h7F}}));
      check_output("win_green", 64'(green_lights), (i < 4) ? 64'(8'hFF) : 64'(0));
    end
    @(negedge clk);
    game_state = 3'd4;
    @(posedge clk);
    #1;
    check_output("lose_msg", 64'(hex_msg), 64'({7'h47, 7'h40, 7'h12, 7'h06}));
    check_output("lose_red", 64'(red_lights), 64'(18'h3FFFF));
    check_output("lose_green", 64'(green_lights), 64'(0));
    @(negedge clk); game_state = 3'd1; repeat (10) @(negedge clk);
    game_state = 3'd2; repeat (3) @(negedge clk);
    check_output("tie_lights", 64'({red_lights, green_lights}), 64'(0));
    game_state = 3'd5; repeat (3) @(negedge clk);
    game_state = 3'd6; repeat (3) @(negedge clk);
    check_output("state6_msg", 64'(hex_msg), 64'({4{7'h7F}}));

    // 5: blanking and overflow
    apply_stimulus(5'd0, 5'd31);
    wait_idle(-1, -1, 5'd0, cycles);
    check_output("zero_hand0", 64'(hex_hands[13:0]), 64'({7'h7F, 7'h40}));
    check_output("hand1_31", 64'(hex_hands[27:14]), 64'({7'h30, 7'h79}));
    apply_stimulus(5'd12, 5'd0);
    wait_idle(-1, -1, 5'd0, cycles);
    check_output("narrow_12", 64'(hex_hands_n[6:0]), 64'(7'h3F));
    apply_stimulus(5'd9, 5'd0);
    wait_idle(-1, -1, 5'd0, cycles);
    check_output("narrow_9", 64'(hex_hands_n[6:0]), 64'(7'h10));
    check_output("wide_9", 64'(hex_hands[13:0]), 64'({7'h7F, 7'h10}));

    // 6: reset mid-shift
    @(negedge clk);
    game_state = 3'd4;
    apply_stimulus(5'd17, 5'd3);
    repeat (2) @(negedge clk);
    resetN = 1'b0;
    #1;
    check_output("abort_busy", 64'(busy), 64'(0));
    check_output("abort_hands", 64'(hex_hands), 64'({4{7'h7F}}));
    check_output("abort_red", 64'(red_lights), 64'(0));
    @(negedge clk);
    resetN = 1'b1;
    apply_stimulus(5'd17, 5'd3);
    wait_idle(-1, -1, 5'd0, cycles);
    check_output("after_abort_len", 64'(cycles), 64'(12));
    check_output("after_abort_hands", 64'(hex_hands), 64'({7'h7F, 7'h30, 7'h79, 7'h78}));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hand_display_controller.md
Name: hand_display_controller

Overview:
- Parametrised seven-segment display controller for the blackjack board.
- Converts NUM_HANDS binary hand totals to decimal digits with a sequential double-dabble engine, and commits all hands to the display together.
- Drives a 4-glyph game-result message with blinking for wins and status LED banks.
- Sits between the game FSM and the board HEX/LED pins. Segment outputs are active-low.

Parameters:
NUM_HANDS, 2, number of hands displayed (index 0 = player, 1 = dealer, ...)
VALUE_W, 5, width of each binary hand total
DIGITS_PER_HAND, 2, decimal digits shown per hand
BLINK_DIV, 25000000, clock cycles per blink half-period

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
handValues  in  NUM_HANDS*VALUE_W  packed hand totals; hand i at [i*VALUE_W +: VALUE_W]
update  in  1  single-cycle strobe requesting conversion of handValues
gameState  in  3  0 PLAY, 1 BLJK, 2 TIE, 3 WIN, 4 LOSE, 5 BUST, 6-7 treated as PLAY
hexHands  out  NUM_HANDS*DIGITS_PER_HAND*7  hand i digit d (d=0 units) at [(i*DIGITS_PER_HAND+d)*7 +: 7]
hexMsg  out  28  message glyphs; [27:21] leftmost … [6:0] rightmost
busy  out  1  conversion in progress
redLights  out  18  loss indicator bank
greenLights  out  8  win indicator bank

Behaviour:
- Reset (async assert, sync release):
  - all hexHands and hexMsg glyphs = 7'h7F (blank)
  - busy = 0, pending = 0, lights = 0, blink counter = 0, blink phase = visible
- Segment code format: {g,f,e,d,c,b,a}, 0 = lit.
  - Digits 0-9: 40 79 24 30 19 12 02 78 00 10 (hex).
  - Letters: b=03, L=47, J=61, H=09, t=07, I=79, E=06, U=41, n=2B, O=40, S=12.
  - Dash = 3F, blank = 7F.
- Conversion FSM: states IDLE → SHIFT → STORE → (next hand: SHIFT | last hand: COMMIT-in-STORE) → IDLE.
  - update sampled high in IDLE: latch all of handValues, hand index = 0, enter SHIFT. busy goes high the next cycle.
  - SHIFT: VALUE_W double-dabble iterations, one per cycle. The add-3 correction happens within the same cycle.
  - STORE: 1 cycle. Writes the hand's glyphs into staging registers.
  - busy stays high for exactly NUM_HANDS*(VALUE_W+1) cycles.
  - hexHands loads from staging on the edge where busy falls. All hands change on the same edge; there is never a partial update.
- Glyph rules per hand:
  - Leading-zero blanking: the most-significant zero digits are blank, but the units digit is always shown (value 0 → units "0").
  - If the value is ≥ 10^DIGITS_PER_HAND, every digit of that hand shows dash.
- update while busy:
  - Sets pending (1 deep; further strobes are absorbed).
  - On completion, hexHands commits, then the FSM re-latches handValues and restarts directly. busy stays high with no gap.
  - update in the same cycle as completion behaves as pending.
- Message path (independent of busy, 1-cycle registered latency from gameState):
  - PLAY: 4 blanks
  - BLJK: "bLJH"
  - TIE: blank,"tIE"
  - WIN: "UUIn"
  - LOSE: "LOSE"
  - BUST: "bUSt"
- Blink:
  - Free-running counter wraps at BLINK_DIV-1 and toggles the phase.
  - Any change of gameState clears the counter and sets phase visible.
  - BLJK and WIN blank hexMsg and greenLights during the hidden phase. All other states are steady.
- Lights:
  - greenLights = 8'hFF for BLJK/WIN in the visible phase, else 0.
  - redLights = all ones for LOSE/BUST, else 0.
  - TIE: both banks 0.
- Reset mid-conversion: aborts immediately. Staging registers are discarded and outputs return to reset values.

Test Plan:
Each scenario uses NUM_HANDS=2, VALUE_W=5, DIGITS_PER_HAND=2, BLINK_DIV=4 unless it states otherwise.
1. Reset asserted then released → every glyph = 7F, busy=0, redLights=0, greenLights=0.
2. Conversion:
   - Stimulus: handValues hand0=21, hand1=7, update pulse.
   - Response: busy high 12 cycles; then hand0 = {24,79}, hand1 = {7F,78}, both updating on the same edge.
3. update while busy:
   - Stimulus: update during busy with hand0 changed to 30.
   - Response: first result commits; busy stays high a further 12 cycles; final hand0 = {30,40}.
4. gameState=WIN:
   - Response: hexMsg = "UUIn" with greenLights=FF for 4 cycles, then blank with greenLights=00 for 4, repeating.
   - Switching to LOSE mid-hidden-phase → "LOSE" steady next cycle, redLights=3FFFF.
5. Blanking and overflow boundaries:
   - hand0=0 → {7F,40}.
   - With DIGITS_PER_HAND=1, hand0=12 → 3F; hand0=9 → 10.
6. Reset asserted mid-SHIFT → busy drops asynchronously, glyphs 7F; a later update converts normally.
